ysyx_22050612_ifu: RTL and testbench

Instruction fetch unit sitting directly upstream of the execute stage in the multi-cycle RV64 core. It holds the architectural PC and issues one fetch request per instruction to instruction memory over a valid/ready request and response interface. It selects the 32-bit instruction word from the 64-bit memory beat and presents it with its PC to decode/execute under valid/ready. It fetches non-speculatively: the next fetch starts only after execute returns the next PC (dnpc) through a commit pulse.

---
 rtl/ysyx_22050612_ifu.sv | 123 ++++++++++++
 tb/tb_ysyx_22050612_ifu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - non-speculative instruction fetch unit for the multi-cycle RV64 core
//
// Purpose: holds the architectural PC, issues one instruction-memory request
// per instruction, extracts the 32-bit word from the 64-bit beat and hands it
// downstream with its PC. The next fetch begins only after execute commits
// the next PC.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   imem_req_*          fetch request (valid/ready, 8-byte-aligned address)
//   imem_resp_*         read response (single-cycle valid pulse, data, error)
//   inst_valid/ready    instruction handshake to decode/execute
//   inst, inst_pc       instruction word and its PC
//   commit_valid/dnpc   retire pulse with the next PC from execute
//   fetch_err           sticky fault flag (access fault or misaligned dnpc)
//   fetch_count         number of instructions accepted downstream
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [63:0]      imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [63:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [63:0]      inst_pc,
  input  logic             commit_valid,
  input  logic [63:0]      commit_dnpc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_REQ         = 3'd0,
    S_WAIT_RESP   = 3'd1,
    S_HOLD        = 3'd2,
    S_WAIT_COMMIT = 3'd3,
    S_ERR         = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [63:0]      inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 64'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_REQ: begin
        // The request is always valid here, so ready alone completes it.
        if (imem_req_ready) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = S_ERR;
          end else begin
            // pc[2] picks which half of the aligned 8-byte beat holds the word.
            inst_d    = pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_WAIT_COMMIT;
        end
      end
      S_WAIT_COMMIT: begin
        if (commit_valid) begin
          pc_d    = commit_dnpc;
          state_d = (commit_dnpc[1:0] != 2'b00) ? S_ERR : S_REQ;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // Every output is a decode of registered state; no input reaches an output
  // combinationally.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = {pc_q[63:3], 3'b000};
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = (state_q == S_ERR);
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb/tb_ysyx_22050612_ifu.sv - directed scoreboard bench for the instruction fetch unit
module tb_ysyx_22050612_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        commit_valid;
  logic [63:0] commit_dnpc;
  logic        fetch_err;
  logic [63:0] fetch_count;

  ysyx_22050612_ifu #(.RESET_PC(64'h8000_0000), .CNT_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .commit_valid    (commit_valid),
    .commit_dnpc     (commit_dnpc),
    .fetch_err       (fetch_err),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] pc_model;
  logic [63:0] cnt_model;

  localparam logic [63:0] DATA_A = 64'h0010_0073_0000_0413;
  localparam logic [63:0] DATA_B = 64'hdead_beef_0bad_f00d;
  localparam logic [63:0] DATA_C = 64'h1234_5678_9abc_def0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {63'd0, imem_req_valid}, 64'd1);
  endtask

  // One complete fetch: optional request stall, response, optional downstream
  // stall (with spurious commits when spur is set), then the handshake.
  task automatic do_fetch(input string tag, input logic [63:0] data,
                          input int req_stall, input int inst_stall, input bit spur);
    exp_t x;
    wait_req({tag, ".reqv"});
    chk({tag, ".addr"}, imem_req_addr, {pc_model[63:3], 3'b000});
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      step();
      chk({tag, ".stall_reqv"}, {63'd0, imem_req_valid}, 64'd1);
      chk({tag, ".stall_addr"}, imem_req_addr, {pc_model[63:3], 3'b000});
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk({tag, ".req_done"}, {63'd0, imem_req_valid}, 64'd0);
    x.inst = pc_model[2] ? data[63:32] : data[31:0];
    x.pc   = pc_model;
    sb.push_back(x);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    chk({tag, ".ivalid_m1"}, {63'd0, inst_valid}, 64'd1);
    for (int i = 0; i < inst_stall; i++) begin
      if (spur) begin
        commit_valid = 1'b1;
        commit_dnpc  = 64'h8000_1000;
      end
      step();
      chk({tag, ".hold_v"}, {63'd0, inst_valid}, 64'd1);
      chk({tag, ".hold_inst"}, {32'd0, inst}, {32'd0, sb[0].inst});
      chk({tag, ".hold_pc"}, inst_pc, sb[0].pc);
      chk({tag, ".hold_cnt"}, fetch_count, cnt_model);
    end
    commit_valid = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, ".inst"}, {32'd0, inst}, {32'd0, x.inst});
      chk({tag, ".inst_pc"}, inst_pc, x.pc);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    cnt_model = cnt_model + 64'd1;
    chk({tag, ".count"}, fetch_count, cnt_model);
    chk({tag, ".ivalid_off"}, {63'd0, inst_valid}, 64'd0);
    if (spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = DATA_C;
      step();
      imem_resp_valid = 1'b0;
      chk({tag, ".spur_iv"}, {63'd0, inst_valid}, 64'd0);
      chk({tag, ".spur_rv"}, {63'd0, imem_req_valid}, 64'd0);
    end
  endtask

  task automatic do_commit(input string tag, input logic [63:0] dnpc);
    step();
    chk({tag, ".idle"}, {63'd0, imem_req_valid}, 64'd0);
    commit_valid = 1'b1;
    commit_dnpc  = dnpc;
    step();
    commit_valid = 1'b0;
    pc_model = dnpc;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pc_model  = 64'h8000_0000;
    cnt_model = 64'd0;
    sb.delete();
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 64'd0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    commit_valid    = 1'b0;
    commit_dnpc     = 64'd0;
    pc_model        = 64'h8000_0000;
    cnt_model       = 64'd0;
    step();
    step();
    chk("rst.ivalid", {63'd0, inst_valid}, 64'd0);
    chk("rst.err", {63'd0, fetch_err}, 64'd0);
    chk("rst.count", fetch_count, 64'd0);
    chk("rst.inst", {32'd0, inst}, 64'd0);
    chk("rst.inst_pc", inst_pc, 64'd0);
    rst = 1'b0;
    chk("rst.reqv", {63'd0, imem_req_valid}, 64'd1);
    chk("rst.addr", imem_req_addr, 64'h8000_0000);

    // Reset then fetch, lower word.
    do_fetch("f1", DATA_A, 0, 0, 1'b0);
    // Upper word select through dnpc 80000004.
    do_commit("c1", 64'h8000_0004);
    chk("c1.reqv_n1", {63'd0, imem_req_valid}, 64'd1);
    chk("c1.addr", imem_req_addr, 64'h8000_0000);
    do_fetch("f2", DATA_A, 0, 0, 1'b0);
    // Backpressure on both interfaces.
    do_commit("c2", 64'h8000_0010);
    do_fetch("f3", DATA_B, 5, 3, 1'b0);
    // Spurious commit in HOLD and spurious response in WAIT_COMMIT.
    do_commit("c3", 64'h8000_001c);
    do_fetch("f4", DATA_B, 0, 2, 1'b1);
    do_commit("c4", 64'h8000_0008);
    chk("c4.addr", imem_req_addr, 64'h8000_0008);
    do_fetch("f5", DATA_C, 1, 0, 1'b0);

    // Misaligned dnpc.
    do_commit("c5", 64'h8000_0002);
    chk("mis.err", {63'd0, fetch_err}, 64'd1);
    chk("mis.reqv", {63'd0, imem_req_valid}, 64'd0);
    imem_req_ready = 1'b1;
    commit_valid   = 1'b1;
    commit_dnpc    = 64'h8000_0000;
    step();
    step();
    imem_req_ready = 1'b0;
    commit_valid   = 1'b0;
    chk("mis.sticky", {63'd0, fetch_err}, 64'd1);
    chk("mis.reqv2", {63'd0, imem_req_valid}, 64'd0);
    chk("mis.iv", {63'd0, inst_valid}, 64'd0);
    apply_reset();
    chk("mis.rst_err", {63'd0, fetch_err}, 64'd0);
    chk("mis.rst_cnt", fetch_count, 64'd0);

    // Access fault on the response.
    wait_req("flt.reqv");
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    imem_resp_data  = DATA_A;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    chk("flt.err", {63'd0, fetch_err}, 64'd1);
    chk("flt.iv", {63'd0, inst_valid}, 64'd0);
    chk("flt.reqv", {63'd0, imem_req_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    inst_ready      = 1'b1;
    step();
    step();
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    chk("flt.sticky", {63'd0, fetch_err}, 64'd1);
    chk("flt.iv2", {63'd0, inst_valid}, 64'd0);
    #2 rst = 1'b1;
    #1 chk("flt.async_clr", {63'd0, fetch_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pc_model  = 64'h8000_0000;
    cnt_model = 64'd0;
    sb.delete();

    // Async reset while waiting on a response, then a stale response.
    do_fetch("g1", DATA_B, 0, 0, 1'b0);
    do_commit("g1c", 64'h8000_0020);
    wait_req("ar.reqv");
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("ar.wait", {63'd0, imem_req_valid}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar.reqv_imm", {63'd0, imem_req_valid}, 64'd1);
    chk("ar.addr_imm", imem_req_addr, 64'h8000_0000);
    chk("ar.cnt_imm", fetch_count, 64'd0);
    chk("ar.inst_imm", {32'd0, inst}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pc_model  = 64'h8000_0000;
    cnt_model = 64'd0;
    sb.delete();
    imem_resp_valid = 1'b1;
    imem_resp_data  = DATA_C;
    step();
    imem_resp_valid = 1'b0;
    chk("ar.stale_iv", {63'd0, inst_valid}, 64'd0);
    chk("ar.stale_reqv", {63'd0, imem_req_valid}, 64'd1);
    chk("ar.stale_inst", {32'd0, inst}, 64'd0);
    // Fresh fetch from reset PC, with ready already high as inst_valid rises.
    chk("ar.addr", imem_req_addr, 64'h8000_0000);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = DATA_A;
    inst_ready      = 1'b1;
    e.inst = DATA_A[31:0];
    e.pc   = 64'h8000_0000;
    sb.push_back(e);
    step();
    imem_resp_valid = 1'b0;
    chk("sim.iv", {63'd0, inst_valid}, 64'd1);
    e = sb.pop_front();
    chk("sim.inst", {32'd0, inst}, {32'd0, e.inst});
    chk("sim.pc", inst_pc, e.pc);
    step();
    inst_ready = 1'b0;
    chk("sim.cnt", fetch_count, 64'd1);
    chk("sim.iv_off", {63'd0, inst_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
